// File: rtl/musk_mem_arbiter.sv
// Two-master arbiter (instruction fetch, data) in front of one shared cache line port.
// One transaction in flight; data has priority, bounded by a fetch starvation counter.
module musk_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int LINE_W       = 512,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_reqcyc,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_respcyc,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_reqcyc,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_respcyc,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_reqcyc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_respcyc,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: requesters hold a level request with stable payload until their
  // one-cycle respcyc; the line port takes a one-cycle mem_reqcyc and answers with
  // a one-cycle mem_respcyc, which only counts while waiting for it.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(63);

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_q, owner_d;  // 1 = data master owns the transaction
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_data, grant_fetch;

  always_comb begin
    grant_data  = d_reqcyc && !(i_reqcyc && (starve_q == LIMIT));
    grant_fetch = i_reqcyc && !grant_data;
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = REQ;
          owner_d     = 1'b1;
          mem_addr_d  = d_addr & LINE_MASK;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          // Count only data grants that actually made fetch wait.
          if (!i_reqcyc)              starve_d = '0;
          else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
        end else if (grant_fetch) begin
          state_d     = REQ;
          owner_d     = 1'b0;
          mem_addr_d  = i_addr & LINE_MASK;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end
      REQ:  state_d = WAIT;
      WAIT: begin
        if (mem_respcyc) begin
          state_d = RESP;
          if (!owner_q)       i_rdata_d = mem_rdata;
          else if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_reqcyc = (state_q == REQ);
  assign i_respcyc  = (state_q == RESP) && !owner_q;
  assign d_respcyc  = (state_q == RESP) && owner_q;
  assign busy       = (state_q != IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_musk_mem_arbiter.sv
// Directed and randomized checks of musk_mem_arbiter against a transaction-level model
// of grant priority, starvation bound, line address alignment and read data capture.
module tb_musk_mem_arbiter;
  localparam int ADDR_W       = 64;
  localparam int LINE_W       = 512;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_reqcyc, i_respcyc;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              d_reqcyc, d_we, d_respcyc;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata, d_rdata;
  logic              mem_reqcyc, mem_we, mem_respcyc;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic              busy;
  logic [1:0]        dbg_state;

  int                checks = 0;
  int                errors = 0;
  logic [ADDR_W-1:0] exp_q[$];
  int                starve_cnt;
  logic [LINE_W-1:0] exp_i_rdata, exp_d_rdata;
  string             grant_log;
  logic              obs;
  logic [LINE_W-1:0] wline;

  musk_mem_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_addr(i_addr), .i_respcyc(i_respcyc), .i_rdata(i_rdata),
    .d_reqcyc(d_reqcyc), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_respcyc(d_respcyc), .d_rdata(d_rdata),
    .mem_reqcyc(mem_reqcyc), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_respcyc(mem_respcyc), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard comparisons
  task automatic chk_bit(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chk_addr(input string tag, input logic [ADDR_W-1:0] o, input logic [ADDR_W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_line(input string tag, input logic [LINE_W-1:0] o, input logic [LINE_W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    starve_cnt  = 0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    exp_q.delete();
  endtask

  // Driver + model: called at an IDLE negedge with at least one request raised.
  // Predicts the winner, plays the line port with latency lat, returns at the RESP negedge.
  task automatic serve(input int lat, output logic obs_data);
    logic              pick_d, we;
    logic [ADDR_W-1:0] a, exp_addr;
    logic [LINE_W-1:0] wd, rd;
    chk_bit("idle_busy", busy, 1'b0);
    chk_bit("idle_i_resp", i_respcyc, 1'b0);
    chk_bit("idle_d_resp", d_respcyc, 1'b0);
    chk_line("hold_i_rdata", i_rdata, exp_i_rdata);
    chk_line("hold_d_rdata", d_rdata, exp_d_rdata);
    pick_d = d_reqcyc && !(i_reqcyc && starve_cnt == STARVE_LIMIT);
    a  = pick_d ? d_addr : i_addr;
    we = pick_d && d_we;
    wd = d_wdata;
    if (pick_d && i_reqcyc) starve_cnt = (starve_cnt < STARVE_LIMIT) ? starve_cnt + 1 : STARVE_LIMIT;
    else                    starve_cnt = 0;
    exp_q.push_back({a[ADDR_W-1:6], 6'b0});
    step();
    exp_addr = exp_q.pop_front();
    chk_bit("req_pulse", mem_reqcyc, 1'b1);
    chk_addr("req_addr", mem_addr, exp_addr);
    chk_bit("req_we", mem_we, we);
    if (we) chk_line("req_wdata", mem_wdata, wd);
    // Idle requester's payload wanders; the latched request must not follow it.
    if (!i_reqcyc) i_addr = rand_addr();
    if (!d_reqcyc) begin
      d_addr  = rand_addr();
      d_wdata = rand_line();
      d_we    = 1'($urandom_range(0, 1));
    end
    step();
    chk_bit("wait_req_low", mem_reqcyc, 1'b0);
    chk_bit("wait_busy", busy, 1'b1);
    repeat (lat - 1) step();
    rd          = rand_line();
    mem_respcyc = 1'b1;
    mem_rdata   = rd;
    step();
    mem_respcyc = 1'b0;
    if (!pick_d)  exp_i_rdata = rd;
    else if (!we) exp_d_rdata = rd;
    chk_bit("resp_i", i_respcyc, !pick_d);
    chk_bit("resp_d", d_respcyc, pick_d);
    chk_line("resp_i_rdata", i_rdata, exp_i_rdata);
    chk_line("resp_d_rdata", d_rdata, exp_d_rdata);
    chk_addr("resp_addr_held", mem_addr, exp_addr);
    chk_bit("resp_we_held", mem_we, we);
    obs_data = d_respcyc;
    if (d_respcyc) grant_log = {grant_log, "D"};
    else           grant_log = {grant_log, "I"};
  endtask

  initial begin
    reset = 1'b1;
    i_reqcyc = 1'b0; i_addr = '0;
    d_reqcyc = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0;
    mem_respcyc = 1'b0; mem_rdata = '0;
    model_reset();
    grant_log = "";
    repeat (3) step();
    chk_bit("rst_mem_reqcyc", mem_reqcyc, 1'b0);
    chk_bit("rst_i_respcyc", i_respcyc, 1'b0);
    chk_bit("rst_d_respcyc", d_respcyc, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_mem_we", mem_we, 1'b0);
    chk_addr("rst_mem_addr", mem_addr, '0);
    chk_line("rst_mem_wdata", mem_wdata, '0);
    chk_line("rst_i_rdata", i_rdata, '0);
    chk_line("rst_d_rdata", d_rdata, '0);
    reset = 1'b0;
    step();

    // Fetch only, unaligned address, latency 3
    i_addr   = 64'h4000_0027;
    i_reqcyc = 1'b1;
    serve(3, obs);
    chk_bit("fetch_owner", obs, 1'b0);
    chk_addr("fetch_aligned_addr", mem_addr, 64'h4000_0000);
    chk_bit("fetch_we", mem_we, 1'b0);
    i_reqcyc = 1'b0;
    step();

    // Simultaneous requests: data write first, then fetch
    wline    = rand_line();
    d_addr   = 64'h80; d_we = 1'b1; d_wdata = wline; d_reqcyc = 1'b1;
    i_addr   = 64'h1234_5678_9abc_def0; i_reqcyc = 1'b1;
    serve(2, obs);
    chk_bit("sim_first_data", obs, 1'b1);
    chk_addr("sim_addr", mem_addr, 64'h80);
    chk_bit("sim_we", mem_we, 1'b1);
    chk_line("sim_wdata", mem_wdata, wline);
    chk_line("sim_d_rdata_kept", d_rdata, '0);
    d_reqcyc = 1'b0; d_we = 1'b0;
    step();
    serve(2, obs);
    chk_bit("sim_then_fetch", obs, 1'b0);
    chk_addr("sim_fetch_addr", mem_addr, 64'h1234_5678_9abc_dec0);
    i_reqcyc = 1'b0;
    step();

    // Starvation bound with both masters saturating
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    step();
    grant_log = "";
    i_addr = rand_addr(); i_reqcyc = 1'b1;
    d_addr = rand_addr(); d_we = 1'b0; d_wdata = rand_line(); d_reqcyc = 1'b1;
    for (int n = 0; n < 10; n++) begin
      serve(1 + n % 3, obs);
      if (obs) d_addr = rand_addr();
      else     i_addr = rand_addr();
      step();
    end
    checks++;
    assert (grant_log == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL grant_order: observed %s expected %s", grant_log, "DDDDIDDDDI");
    end
    i_reqcyc = 1'b0; d_reqcyc = 1'b0;
    step();

    // Reset while waiting on the line port; the late response must be dropped
    d_addr = rand_addr(); d_we = 1'b0; d_reqcyc = 1'b1;
    step();
    chk_bit("rw_req", mem_reqcyc, 1'b1);
    step();
    chk_bit("rw_wait_busy", busy, 1'b1);
    reset = 1'b1; d_reqcyc = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    repeat (2) step();
    mem_respcyc = 1'b1; mem_rdata = rand_line();
    step();
    mem_respcyc = 1'b0;
    chk_bit("rw_no_i_resp", i_respcyc, 1'b0);
    chk_bit("rw_no_d_resp", d_respcyc, 1'b0);
    chk_bit("rw_busy", busy, 1'b0);
    chk_bit("rw_mem_reqcyc", mem_reqcyc, 1'b0);
    chk_bit("rw_mem_we", mem_we, 1'b0);
    chk_addr("rw_mem_addr", mem_addr, '0);
    chk_line("rw_mem_wdata", mem_wdata, '0);
    chk_line("rw_i_rdata", i_rdata, '0);
    chk_line("rw_d_rdata", d_rdata, '0);
    step();
    chk_bit("rw_no_d_resp_later", d_respcyc, 1'b0);
    chk_bit("rw_busy_later", busy, 1'b0);

    // Spurious line-port response while idle
    i_addr = rand_addr(); i_reqcyc = 1'b1;
    serve(2, obs);
    i_reqcyc = 1'b0;
    step();
    d_addr = rand_addr(); d_we = 1'b0; d_reqcyc = 1'b1;
    serve(1, obs);
    d_reqcyc = 1'b0;
    step();
    mem_respcyc = 1'b1; mem_rdata = '1;
    step();
    mem_respcyc = 1'b0;
    chk_line("sp_i_rdata", i_rdata, exp_i_rdata);
    chk_line("sp_d_rdata", d_rdata, exp_d_rdata);
    chk_bit("sp_busy", busy, 1'b0);
    chk_bit("sp_i_resp", i_respcyc, 1'b0);
    chk_bit("sp_d_resp", d_respcyc, 1'b0);
    i_addr = rand_addr(); i_reqcyc = 1'b1;
    serve(4, obs);
    chk_bit("sp_fetch_owner", obs, 1'b0);
    i_reqcyc = 1'b0;
    step();

    // Randomized traffic with stray responses during RESP
    for (int n = 0; n < 60; n++) begin
      if (!i_reqcyc && !d_reqcyc) begin
        if ($urandom_range(0, 1) == 0) i_reqcyc = 1'b1;
        else                           d_reqcyc = 1'b1;
      end
      serve(int'($urandom_range(1, 5)), obs);
      if (obs) begin
        d_reqcyc = 1'($urandom_range(0, 1));
        d_addr   = rand_addr();
        d_we     = 1'($urandom_range(0, 1));
        d_wdata  = rand_line();
        if (!i_reqcyc) i_reqcyc = 1'($urandom_range(0, 1));
      end else begin
        i_reqcyc = 1'($urandom_range(0, 1));
        i_addr   = rand_addr();
        if (!d_reqcyc) d_reqcyc = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) == 1) begin
        mem_respcyc = 1'b1;
        mem_rdata   = rand_line();
      end
      step();
      mem_respcyc = 1'b0;
    end
    i_reqcyc = 1'b0; d_reqcyc = 1'b0;
    step();
    chk_line("end_i_rdata", i_rdata, exp_i_rdata);
    chk_line("end_d_rdata", d_rdata, exp_d_rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/musk_mem_arbiter.md
MUSK_MEM_ARBITER -- requirements
Module: musk_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, address width in bits.
REQ-002 Parameter LINE_W, 512, line data width in bits (64 bytes).
REQ-003 Parameter STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (1..15).
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 i_reqcyc  in  1  fetch read request, level, held with i_addr stable until i_respcyc.
REQ-007 i_addr  in  ADDR_W  fetch line address.
REQ-008 i_respcyc  out  1  one-cycle pulse: fetch request complete, i_rdata valid.
REQ-009 i_rdata  out  LINE_W  fetch line data, held until the next fetch completion.
REQ-010 d_reqcyc  in  1  data request, level, held with d_addr/d_we/d_wdata stable until d_respcyc.
REQ-011 d_addr  in  ADDR_W  data line address.
REQ-012 d_we  in  1  1 = line write, 0 = line read.
REQ-013 d_wdata  in  LINE_W  write line data.
REQ-014 d_respcyc  out  1  one-cycle pulse: data request complete.
REQ-015 d_rdata  out  LINE_W  data read line, held until the next data read completion.
REQ-016 mem_reqcyc  out  1  one-cycle request pulse to the shared line port (cache).
REQ-017 mem_addr  out  ADDR_W  registered line address, bits [5:0] forced to 0.
REQ-018 mem_we  out  1  registered write enable.
REQ-019 mem_wdata  out  LINE_W  registered write data.
REQ-020 mem_respcyc  in  1  line port completion pulse.
REQ-021 mem_rdata  in  LINE_W  line port read data, valid with mem_respcyc.
REQ-022 busy  out  1  high whenever state is not IDLE.

Function
REQ-023 FSM states IDLE, REQ, WAIT, RESP; exactly one transaction outstanding.
REQ-024 IDLE: if any request is high, grant one, latch its addr (low 6 bits zeroed), we (0 for fetch) and wdata into mem_* registers, record owner, go to REQ; else stay.
REQ-025 Arbitration: data wins over fetch, except fetch wins when both request and the starvation counter equals STARVE_LIMIT.
REQ-026 Starvation counter: +1 (saturating at STARVE_LIMIT) on a data grant with i_reqcyc=1; cleared on a fetch grant or on a data grant with i_reqcyc=0.
REQ-027 REQ: mem_reqcyc=1 for exactly this cycle, then WAIT unconditionally.
REQ-028 WAIT: hold until mem_respcyc=1; then capture mem_rdata into the owner's rdata register (reads only; writes leave d_rdata unchanged) and go to RESP.
REQ-029 RESP: assert the owner's respcyc for exactly this cycle, then IDLE; requester drops or changes its request the same cycle, so the earliest re-grant is the following IDLE cycle.
REQ-030 Latency: grant cycle to mem_reqcyc = 1 cycle; mem_respcyc to requester respcyc = 1 cycle; minimum turnaround 4 cycles plus line-port latency.
REQ-031 mem_respcyc in IDLE, REQ or RESP is ignored (no state or data change).
REQ-032 Requests are sampled only in IDLE; input changes during REQ/WAIT/RESP do not affect the latched mem_addr, mem_we or mem_wdata.
REQ-033 i_respcyc and d_respcyc are never high in the same cycle; mem_reqcyc is never high outside REQ.

Reset
REQ-034 On reset: state IDLE, counter 0, mem_reqcyc/i_respcyc/d_respcyc/busy/mem_we = 0, mem_addr/mem_wdata/i_rdata/d_rdata = 0.
REQ-035 Reset mid-transaction abandons it: no respcyc is issued for it, and a later mem_respcyc for it is ignored per REQ-031.

Verification
REQ-036 Fetch only: i_reqcyc=1, i_addr=0x4000_0027, line port latency 3 -> mem_reqcyc 1 cycle after grant with mem_addr=0x4000_0000, mem_we=0; i_respcyc 1 cycle after mem_respcyc, i_rdata = mem_rdata.
REQ-037 Simultaneous: i_reqcyc and d_reqcyc rise together, d_we=1, d_addr=0x80 -> data granted first, mem_we=1, mem_wdata=d_wdata; d_respcyc pulses and d_rdata is unchanged; fetch granted next.
REQ-038 Starvation: d_reqcyc held high with a new address each completion, i_reqcyc held high, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-039 Reset asserted in WAIT, then mem_respcyc arrives 2 cycles after reset deasserts -> no i_respcyc/d_respcyc, state remains IDLE, all outputs at reset values.
REQ-040 Spurious mem_respcyc in IDLE with mem_rdata=all-ones -> i_rdata, d_rdata and state unchanged; a later normal fetch completes with correct data.
